// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg
//   Shared definitions for the fetch path: program-counter width, reset vector,
//   return-stack geometry, and the next-PC selector codes used by the decoder
//   and the 3-way selector that feeds pc_stack.pc_next_in.
package pc_stack_pkg;

    localparam int unsigned PC_ADDR_WIDTH   = 32'd12;
    localparam int unsigned PC_RESET_VECTOR = 32'd0;
    localparam int unsigned PC_STACK_DEPTH  = 32'd31;
    localparam int unsigned PC_PTR_WIDTH    = 32'd5;

    // Next-PC selector codes: data0 = pc_inc, data1 = branch target, data2 = stack_top.
    typedef enum logic [1:0] {
        SEL_INC    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_RETURN = 2'b10
    } next_pc_sel_e;

endpackage : pc_stack_pkg

// File: rtl/lifo_stack.sv
// lifo_stack
//   DEPTH x WIDTH register-array return stack with depth counter.
//   push and pop arrive already qualified by the caller.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset (depth only)
//     push, pop       requests; both together replace the top entry
//     wr_data         value written on push / replace
//     top             newest entry, 0 while empty
//     depth           number of valid entries
//     empty, full     depth == 0 / depth == DEPTH
module lifo_stack
    import pc_stack_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_ADDR_WIDTH,
    parameter int unsigned DEPTH     = PC_STACK_DEPTH,
    parameter int unsigned PTR_WIDTH = PC_PTR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [WIDTH-1:0]     top,
    output logic [PTR_WIDTH-1:0] depth,
    output logic                 empty,
    output logic                 full
);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [PTR_WIDTH-1:0] depth_r;
    logic [PTR_WIDTH-1:0] depth_nxt_s;
    logic [PTR_WIDTH-1:0] wr_idx_s;
    logic [PTR_WIDTH-1:0] top_idx_s;
    logic                 wr_en_s;
    logic                 empty_s;
    logic                 full_s;

    assign top_idx_s = depth_r - PTR_WIDTH'(1);
    assign empty_s   = (depth_r == {PTR_WIDTH{1'b0}});
    assign full_s    = (depth_r == PTR_WIDTH'(DEPTH));

    // Next depth and write port decode for every push/pop combination.
    always_comb begin
        depth_nxt_s = depth_r;
        wr_en_s     = 1'b0;
        wr_idx_s    = depth_r;
        case ({push, pop})
            2'b10: begin
                if (!full_s) begin
                    wr_en_s     = 1'b1;
                    depth_nxt_s = depth_r + PTR_WIDTH'(1);
                end else begin
                    wr_en_s     = 1'b0;
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    depth_nxt_s = top_idx_s;
                end else begin
                    depth_nxt_s = depth_r;
                end
            end
            2'b11: begin
                // Replace the top entry; on an empty stack this degenerates to a push.
                wr_en_s = 1'b1;
                if (!empty_s) begin
                    wr_idx_s = top_idx_s;
                end else begin
                    wr_idx_s    = depth_r;
                    depth_nxt_s = depth_r + PTR_WIDTH'(1);
                end
            end
            default: begin
                depth_nxt_s = depth_r;
            end
        endcase
    end

    // Depth counter; the only reset state of the stack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_r <= {PTR_WIDTH{1'b0}};
        end else begin
            depth_r <= depth_nxt_s;
        end
    end

    // Entry storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data;
        end
    end

    // Forced to 0 while empty so no uninitialised entry ever reaches the selector.
    always_comb begin
        if (empty_s) begin
            top = {WIDTH{1'b0}};
        end else begin
            top = mem_r[top_idx_s];
        end
    end

    assign depth = depth_r;
    assign empty = empty_s;
    assign full  = full_s;

endmodule : lifo_stack

// File: rtl/pc_stack.sv
// pc_stack
//   Fetch-address register, incrementer and hardware return-address stack.
//   pc_inc and stack_top feed the next-PC selector, whose result returns as
//   pc_next_in; CALL pushes pc_q+1, RETURN pops.
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     pc_en                      advance PC; also qualifies push/pop
//     pc_next_in                 next PC from the selector
//     push, pop                  CALL / RETURN requests
//     pc_q                       registered fetch address
//     pc_inc                     pc_q+1, wraps
//     stack_top                  newest return address, 0 when empty
//     stack_depth                valid entries
//     stack_empty, stack_full    depth status
//     stack_overflow/underflow   sticky refused-push / refused-pop flags
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = PC_ADDR_WIDTH,
    parameter int unsigned DEPTH        = PC_STACK_DEPTH,
    parameter int unsigned PTR_WIDTH    = PC_PTR_WIDTH,
    parameter int unsigned RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_en,
    input  logic [ADDR_WIDTH-1:0] pc_next_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] pc_q,
    output logic [ADDR_WIDTH-1:0] pc_inc,
    output logic [ADDR_WIDTH-1:0] stack_top,
    output logic [PTR_WIDTH-1:0]  stack_depth,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  ovf_r;
    logic                  unf_r;
    logic                  ovf_set_s;
    logic                  unf_set_s;

    assign pc_inc_s = pc_r + ADDR_WIDTH'(1);
    assign push_s   = pc_en & push;
    assign pop_s    = pc_en & pop;

    // A lone push on a full stack is refused; push+pop on a full stack is a legal replace.
    // Any pop on an empty stack is refused, even when paired with a push.
    always_comb begin
        if (push_s && !pop_s && full_s) begin
            ovf_set_s = 1'b1;
        end else begin
            ovf_set_s = 1'b0;
        end
        if (pop_s && empty_s) begin
            unf_set_s = 1'b1;
        end else begin
            unf_set_s = 1'b0;
        end
    end

    // PC register and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r  <= ADDR_WIDTH'(RESET_VECTOR);
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (pc_en) begin
                pc_r <= pc_next_in;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    lifo_stack #(
        .WIDTH     (ADDR_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (pc_inc_s),
        .top     (stack_top),
        .depth   (stack_depth),
        .empty   (empty_s),
        .full    (full_s)
    );

    assign pc_q            = pc_r;
    assign pc_inc          = pc_inc_s;
    assign stack_empty     = empty_s;
    assign stack_full      = full_s;
    assign stack_overflow  = ovf_r;
    assign stack_underflow = unf_r;

endmodule : pc_stack
